// File: rtl/pmem_line_responder.sv
// Line-granular backing store for the cache's pmem_* port: one 256-bit line
// transaction at a time, completed with a one-cycle pmem_resp after LATENCY cycles.
module pmem_line_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         proto_err
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_BUSY   = 2'd1;
  localparam logic [1:0]  ST_DONE   = 2'd2;
  localparam int unsigned NUM_LINES = 2 ** INDEX_BITS;
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 32'd1);
  localparam bit          SKIP_BUSY = (LATENCY == 32'd1);

  logic [255:0]          mem_q [NUM_LINES];
  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [255:0]          wdata_q, wdata_d;
  logic [255:0]          rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [INDEX_BITS-1:0] addr_idx_s;
  logic [INDEX_BITS-1:0] rd_idx_s;
  logic [255:0]          rd_line_s;
  logic                  req_held_s;
  logic                  mem_we_s;
  logic                  unused_addr_s;

  assign addr_idx_s    = pmem_address[5 +: INDEX_BITS];
  assign unused_addr_s = ^{pmem_address[4:0], pmem_address[15:5+INDEX_BITS]};
  // With LATENCY==1 the read is captured straight out of IDLE, before the latch exists.
  assign rd_idx_s      = (state_q == ST_IDLE) ? addr_idx_s : idx_q;
  assign rd_line_s     = mem_q[rd_idx_s];
  assign req_held_s    = wr_q ? pmem_write : pmem_read;
  assign mem_we_s      = (state_q == ST_DONE) && wr_q && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pmem_write || pmem_read) begin
          wr_d    = pmem_write;
          idx_d   = addr_idx_s;
          wdata_d = pmem_wdata;
          cnt_d   = CNT_LOAD;
          if (pmem_write && pmem_read) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (SKIP_BUSY) begin
            state_d = ST_DONE;
            if (!pmem_write) begin
              rdata_d = rd_line_s;
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A dropped request is a protocol violation and takes precedence over completion.
        if (!req_held_s) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          err_d   = 1'b1;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
          if (!wr_q) begin
            rdata_d = rd_line_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 256'd0;
      rdata_q <= 256'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The line array is deliberately outside reset; reset only blocks the pending write.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = (state_q == ST_DONE);
  assign proto_err  = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: directed protocol cases plus random traffic,
// checked cycle by cycle against a transaction-level model of the line store.
module tb_pmem_line_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  address;
  logic         read;
  logic         write;
  logic [255:0] wdata;
  logic [255:0] rdata4, rdata1;
  logic         resp4, resp1, err4, err1;

  always #5 clk = ~clk;

  pmem_line_responder #(.LATENCY(4), .INDEX_BITS(5)) u_dut4 (
    .clk(clk), .reset(reset), .pmem_address(address), .pmem_read(read),
    .pmem_write(write), .pmem_wdata(wdata), .pmem_rdata(rdata4),
    .pmem_resp(resp4), .proto_err(err4)
  );

  pmem_line_responder #(.LATENCY(1), .INDEX_BITS(5)) u_dut1 (
    .clk(clk), .reset(reset), .pmem_address(address), .pmem_read(read),
    .pmem_write(write), .pmem_wdata(wdata), .pmem_rdata(rdata1),
    .pmem_resp(resp1), .proto_err(err1)
  );

  int           nvec = 0;
  int           nmis = 0;
  bit           sel1 = 1'b0;
  logic [255:0] mem_m [32];
  bit           valid_m [32];
  logic [255:0] rdata_m = 256'd0;
  bit           err_m = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input string tag, input bit resp_exp);
    chk({tag, ":resp"}, {255'd0, (sel1 ? resp1 : resp4)}, {255'd0, resp_exp});
    chk({tag, ":rdata"}, sel1 ? rdata1 : rdata4, rdata_m);
    chk({tag, ":proto_err"}, {255'd0, (sel1 ? err1 : err4)}, {255'd0, err_m});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    read  = 1'b0;
    write = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      sample("idle", 1'b0);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Issue one request in the current (idle) cycle and follow it to one cycle past
  // its expected response. drop_k / rst_k: cycle after acceptance at which the
  // request is dropped / reset is pulsed (0 = never).
  task automatic txn(input string tag, input bit wr, input bit rd, input logic [15:0] addr,
                     input logic [255:0] data, input int drop_k, input int rst_k);
    int lat;
    int idx;
    bit dead;
    lat     = sel1 ? 1 : 4;
    idx     = (int'(addr) / 32) % 32;
    write   = wr;
    read    = rd;
    address = addr;
    wdata   = data;
    for (int k = 1; k <= lat + 1; k++) begin
      step();
      dead = (drop_k > 0 && k > drop_k) || (rst_k > 0 && k > rst_k);
      if (k == 1 && wr && rd) err_m = 1'b1;
      if (drop_k > 0 && k == drop_k + 1) err_m = 1'b1;
      if (rst_k > 0 && k == rst_k + 1) begin
        rdata_m = 256'd0;
        err_m   = 1'b0;
      end
      if (k == lat && !dead && !wr) rdata_m = mem_m[idx];
      sample(tag, (k == lat) && !dead);
      if (rst_k > 0 && k == rst_k + 1) reset = 1'b0;
      if (k == drop_k) begin
        read  = 1'b0;
        write = 1'b0;
      end
      if (k == rst_k) begin
        reset = 1'b1;
        read  = 1'b0;
        write = 1'b0;
      end
    end
    if (wr && drop_k == 0 && rst_k == 0) begin
      mem_m[idx]   = data;
      valid_m[idx] = 1'b1;
    end
  endtask

  task automatic random_txns(input int n, input bit allow_drop);
    logic [15:0]  a;
    logic [255:0] d;
    int           op;
    int           idx;
    int           drop;
    bit           wr;
    bit           rd;
    for (int i = 0; i < n; i++) begin
      a    = 16'($urandom_range(0, 65535));
      d    = rnd256();
      op   = int'($urandom_range(0, 3));
      idx  = (int'(a) / 32) % 32;
      wr   = (op != 2);
      rd   = (op >= 2);
      if (rd && !wr && !valid_m[idx]) begin
        wr = 1'b1;
        rd = 1'b0;
      end
      drop = (allow_drop && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      txn("rand", wr, rd, a, d, drop, 0);
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  logic [255:0] pat_a5;
  logic [255:0] pat_x;
  logic [255:0] pat_d;

  initial begin
    for (int i = 0; i < 32; i++) valid_m[i] = 1'b0;
    pat_a5  = {32{8'hA5}};
    pat_x   = rnd256();
    pat_d   = rnd256();
    reset   = 1'b1;
    write   = 1'b1;
    read    = 1'b0;
    address = 16'h0040;
    wdata   = pat_a5;

    // Reset held two cycles with a write pending; accepted in first IDLE cycle after.
    step();
    sample("reset0", 1'b0);
    step();
    sample("reset1", 1'b0);
    reset = 1'b0;
    txn("wr40", 1'b1, 1'b0, 16'h0040, pat_a5, 0, 0);
    idle(2);
    txn("rd40", 1'b0, 1'b1, 16'h0040, 256'd0, 0, 0);
    idle(1);

    // Evict-then-fill with no idle gap.
    txn("evict", 1'b1, 1'b0, 16'h0020, pat_x, 0, 0);
    txn("fill", 1'b0, 1'b1, 16'h0020, 256'd0, 0, 0);
    idle(1);

    // Abort by dropping the read, then a normal write with the flag still set.
    txn("abort", 1'b0, 1'b1, 16'h0100, 256'd0, 2, 0);
    txn("postab", 1'b1, 1'b0, 16'h0100, rnd256(), 0, 0);
    idle(1);

    // Simultaneous read and write: the write wins.
    txn("both", 1'b1, 1'b1, 16'h0060, pat_d, 0, 0);
    idle(1);
    txn("rd60", 1'b0, 1'b1, 16'h0060, 256'd0, 0, 0);
    idle(1);

    // Reset during BUSY and during DONE must both suppress the write.
    txn("rstbusy", 1'b1, 1'b0, 16'h0040, ~pat_a5, 0, 2);
    idle(1);
    txn("rdrst1", 1'b0, 1'b1, 16'h0040, 256'd0, 0, 0);
    idle(1);
    txn("rstdone", 1'b1, 1'b0, 16'h0040, ~pat_a5, 0, 4);
    idle(1);
    txn("rdrst2", 1'b0, 1'b1, 16'h0040, 256'd0, 0, 0);
    idle(1);

    random_txns(40, 1'b1);

    // Switch to the LATENCY=1 instance after a common reset.
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    step();
    sel1    = 1'b1;
    rdata_m = 256'd0;
    err_m   = 1'b0;
    for (int i = 0; i < 32; i++) valid_m[i] = 1'b0;
    sample("reset2", 1'b0);
    reset = 1'b0;
    idle(1);
    txn("l1wr0", 1'b1, 1'b0, 16'h0000, pat_d, 0, 0);
    txn("l1alias", 1'b0, 1'b1, 16'h0400, 256'd0, 0, 0);
    idle(1);
    random_txns(20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
# pmem_line_responder

Physical-memory side of the cache's `pmem_*` interface. It accepts one 256-bit line read or write at a time from the cache controller and services it from an on-chip line array. It returns `pmem_resp` after a fixed, parameterised latency. It replaces the behavioural memory model in cache-level simulation and is synthesizable for FPGA bring-up.

## Interface
Parameters:
- `LATENCY`, 4: cycles from the acceptance cycle to the `pmem_resp` cycle. Legal range is 1..15.
- `INDEX_BITS`, 5: line-index width. The array holds 2^INDEX_BITS lines of 256 bits.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: clock; all state changes on the rising edge.
  - `reset`, in, 1: synchronous, active-high reset.
- `pmem_address`, in, 16: byte address. Bits [4:0] are ignored; the line index is `[5+INDEX_BITS-1:5]`; higher bits are ignored, so addresses alias.
- `pmem_read`, in, 1: line read request. The cache controller holds it high until it sees `pmem_resp`.
- `pmem_write`, in, 1: line write request. Held the same way.
- `pmem_wdata`, in, 256: write line.
- `pmem_rdata`, out, 256: read line, registered.
- `pmem_resp`, out, 1: one-cycle completion pulse.
- `proto_err`, out, 1: sticky flag for protocol violations.

## Operation
The state machine has three states: IDLE, BUSY and DONE.

IDLE:
- If `pmem_write` or `pmem_read` is high, latch the request:
  - op: write has priority if both are high.
  - line index.
  - `pmem_wdata`.
- Then load the latency counter with `LATENCY-1` and go to BUSY. If `LATENCY==1`, go straight to DONE.
- Otherwise stay in IDLE.

BUSY:
- Decrement the counter each cycle. When the counter is 1, go to DONE.
- If the latched op's request line (`pmem_read` or `pmem_write`) is sampled low, abort:
  - go to IDLE;
  - no array write, no `pmem_resp`, `pmem_rdata` unchanged;
  - set `proto_err`.
- Address and data are taken from the latch. Changes on the inputs during BUSY are ignored.

DONE:
- `pmem_resp` is high for exactly this cycle, decoded combinationally from the state.
- Read: `pmem_rdata` is loaded with the array line at the edge entering DONE, so it is valid throughout the resp cycle. It holds that value until the next read completes.
- Write: the array line is written with the latched data at the edge leaving DONE.
- Always return to IDLE.

Back-to-back requests:
- A request that is still high in the IDLE cycle after DONE is accepted as a new transaction.
- The cache's evict-then-fill sequence (write resp, read asserted next cycle) therefore needs no idle gap.

Protocol errors:
- `proto_err` is set by either of:
  - `pmem_read` and `pmem_write` high together in an IDLE acceptance cycle; the write is serviced and the read dropped;
  - an abort in BUSY.
- It is cleared only by `reset`.

Counter width is 4 bits. The counter never wraps: BUSY exits at 1.

## Timing
Latency:
- The acceptance cycle A is the IDLE cycle in which the request is sampled high.
- `pmem_resp` is high in cycle A+LATENCY.
- For a held request, the next acceptance cycle is A+LATENCY+1. Sustained throughput is one line per LATENCY+1 cycles.

Reset values:
- State is IDLE.
- `pmem_resp` is 0.
- `pmem_rdata` is 256'h0.
- `proto_err` is 0.
- The counter is 0.
- The latch is cleared.

Reset and the array:
- Reset in BUSY or DONE aborts the transaction: no resp and no array write. Reset wins over the DONE write on the same edge.
- The array is not cleared by reset. It starts all-zero at time 0 for simulation only.

Other rules:
- A read of a line written in the immediately preceding transaction returns the new data. The write lands before the next acceptance can reach DONE.
- `pmem_resp` never asserts in IDLE or BUSY, and never for two consecutive cycles.

## Test plan
- Reset: hold `reset` for 2 cycles with a request high → `pmem_resp`=0, `pmem_rdata`=0, `proto_err`=0 throughout; after release, acceptance happens in the first IDLE cycle.
- Write then read, LATENCY=4: write 0xA5…A5 to address 0x0040, hold until resp; resp lands exactly 4 cycles after acceptance. Then read 0x0040 → `pmem_rdata`=0xA5…A5 in its resp cycle, and in no cycle before it.
- Evict-then-fill: write line X to 0x0020; read of 0x0020 asserted the cycle after the write resp → accepted in that cycle; resp 4 cycles later returns X. Both transactions complete in 10 cycles total.
- Abort: read 0x0100, drop `pmem_read` 2 cycles after acceptance → no resp, `pmem_rdata` unchanged, `proto_err`=1. A following write accepts normally, and `proto_err` stays 1.
- Simultaneous: `pmem_read`=`pmem_write`=1 to 0x0060 with data D → one resp after LATENCY cycles, line written with D, `pmem_rdata` unchanged, `proto_err`=1.
- Aliasing and LATENCY=1: write D to 0x0000, read 0x0400 (INDEX_BITS=5) → returns D; each resp lands in cycle A+1.
